// File: rtl/mips_bus_if.sv
// rtl/mips_bus_if.sv - CPU memory bus between the bus master and the memory responder
interface mips_bus_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_master.sv
// rtl/mips_bus_master.sv - single load/store request to memory bus transaction converter
module mips_bus_master #(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    mips_bus_if.master        bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, CAPT, FIN} state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT > 0 ? MAX_WAIT - 1 : 0);

    state_t             state_q, state_d;
    logic [31:0]        address_q, address_d;
    logic [31:0]        writedata_q, writedata_d;
    logic [3:0]         byteenable_q, byteenable_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               fail_q, fail_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               legal;
    logic [31:0]        shifted;
    logic [31:0]        extended;

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        rdata_d      = rdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        fail_d       = fail_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wait_cnt_d   = wait_cnt_q;
        legal        = (req_size == 2'd0) ||
                       (req_size == 2'd1 && !req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] == 2'b00);
        shifted      = bus.readdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    extended = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'd1:    extended = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: extended = shifted;
        endcase

        case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    wait_cnt_d = '0;
                    if (!legal) begin
                        fail_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        fail_d      = 1'b0;
                        address_d   = {req_addr[31:2], 2'b00};
                        off_d       = req_addr[1:0];
                        size_d      = req_size;
                        signed_d    = req_signed;
                        writedata_d = req_wdata << {req_addr[1:0], 3'b000};
                        case (req_size)
                            2'd0:    byteenable_d = 4'b0001 << req_addr[1:0];
                            2'd1:    byteenable_d = 4'b0011 << req_addr[1:0];
                            default: byteenable_d = 4'b1111;
                        endcase
                        state_d = req_we ? WR : RD;
                    end
                end
            end
            RD, WR: begin
                if (!bus.waitrequest) begin
                    state_d = (state_q == RD) ? CAPT : FIN;
                end else if (MAX_WAIT > 0 && wait_cnt_q == WAIT_LAST) begin
                    // Timeout abandons the transfer; rdata keeps its previous value
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            CAPT: begin
                rdata_d = extended;
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = fail_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fail_q       <= 1'b0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign bus.read       = (state_q == RD);
    assign bus.write      = (state_q == WR);
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// tb/tb_mips_bus_master.sv - scoreboard bench for mips_bus_master with directed vectors
module tb_mips_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;

    mips_bus_if bus ();

    mips_bus_master #(.MAX_WAIT(4), .WAIT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Completion monitor: every done pops one expected response
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_err", {31'b0, err}, {31'b0, e.err});
                chk("done_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdd,
                       input int nwait, input logic exp_err, input logic [31:0] exp_rdata,
                       input int exp_lat, input int exp_cycles, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int cnt;
        int cycles;
        exp_t e;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        req        = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        bus.readdata    = rdd;
        bus.waitrequest = (nwait > 0);
        @(negedge clk);
        req    = 1'b0;
        cnt    = 0;
        cycles = 0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        while (cnt < 20) begin
            if (cnt == 2) req = 1'b0;
            if (done === 1'b1) break;
            bus.waitrequest = (cnt < nwait);
            if (bus.read === 1'b1 || bus.write === 1'b1) begin
                cycles++;
                chk("bus_rw", {30'b0, bus.read, bus.write}, we ? 32'd1 : 32'd2);
                chk("bus_address", bus.address, exp_addr);
                chk("bus_be", {28'b0, bus.byteenable}, {28'b0, exp_be});
                if (we) chk("bus_wdata", bus.writedata, exp_wd);
            end
            if (cnt == 1) req = 1'b1;
            @(negedge clk);
            cnt++;
        end
        req = 1'b0;
        bus.waitrequest = 1'b0;
        chk("latency", cnt, exp_lat);
        chk("bus_cycles", cycles, exp_cycles);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        repeat (2) @(negedge clk);
        chk("rst_address", bus.address, 32'h0);
        chk("rst_rw", {30'b0, bus.read, bus.write}, 32'd0);
        chk("rst_flags", {29'b0, busy, done, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        //  we  sz  sg  addr          wdata         readdata      nw err rdata         lat cyc addr          be       wdata
        txn(0, 2'd2, 0, 32'hBFC00018, 32'h0,        32'hF0F0FF00, 0, 0, 32'hF0F0FF00, 3, 1, 32'hBFC00018, 4'b1111, 32'h0);
        txn(0, 2'd0, 1, 32'hBFC00019, 32'h0,        32'hF0F0FF00, 0, 0, 32'hFFFFFFFF, 3, 1, 32'hBFC00018, 4'b0010, 32'h0);
        txn(0, 2'd0, 0, 32'hBFC00019, 32'h0,        32'hF0F0FF00, 0, 0, 32'h000000FF, 3, 1, 32'hBFC00018, 4'b0010, 32'h0);
        txn(0, 2'd1, 1, 32'hBFC0001A, 32'h0,        32'hF0F0FF00, 0, 0, 32'hFFFFF0F0, 3, 1, 32'hBFC00018, 4'b1100, 32'h0);
        txn(1, 2'd1, 0, 32'hBFC00022, 32'h00001234, 32'h0,        0, 0, 32'hFFFFF0F0, 2, 1, 32'hBFC00020, 4'b1100, 32'h12340000);
        txn(0, 2'd2, 0, 32'hBFC00018, 32'h0,        32'hF0F0FF00, 3, 0, 32'hF0F0FF00, 6, 4, 32'hBFC00018, 4'b1111, 32'h0);
        txn(0, 2'd2, 0, 32'hBFC00002, 32'h0,        32'h12345678, 0, 1, 32'hF0F0FF00, 1, 0, 32'h0,        4'b0000, 32'h0);
        txn(0, 2'd3, 0, 32'hBFC00018, 32'h0,        32'h12345678, 0, 1, 32'hF0F0FF00, 1, 0, 32'h0,        4'b0000, 32'h0);
        txn(1, 2'd0, 0, 32'hBFC0001B, 32'h000000AB, 32'h0,        0, 0, 32'hF0F0FF00, 2, 1, 32'hBFC00018, 4'b1000, 32'hAB000000);
        txn(0, 2'd2, 1, 32'hBFC0001C, 32'h0,        32'h80000001, 0, 0, 32'h80000001, 3, 1, 32'hBFC0001C, 4'b1111, 32'h0);
        txn(0, 2'd1, 0, 32'hBFC0001A, 32'h0,        32'h80010000, 1, 0, 32'h00008001, 4, 2, 32'hBFC00018, 4'b1100, 32'h0);
        txn(0, 2'd2, 0, 32'hBFC00018, 32'h0,        32'hDEADBEEF, 99, 1, 32'h00008001, 5, 4, 32'hBFC00018, 4'b1111, 32'h0);

        // Asynchronous reset in the middle of a stalled read
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'hBFC00018;
        bus.waitrequest = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_rd_read", {31'b0, bus.read}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_read", {31'b0, bus.read}, 32'd0);
        chk("arst_address", bus.address, 32'h0);
        chk("arst_be_wd", {bus.byteenable, bus.writedata[27:0]}, 32'h0);
        chk("arst_flags", {29'b0, busy, done, err}, 32'd0);
        chk("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus.waitrequest = 1'b0;
        @(negedge clk);
        txn(0, 2'd2, 0, 32'hBFC00018, 32'h0, 32'hF0F0FF00, 0, 0, 32'hF0F0FF00, 3, 1, 32'hBFC00018, 4'b1111, 32'h0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
